parity_stream_acc: RTL and testbench
====================================

Name: parity_stream_acc

Overview:
- Parametrised streaming parity generator/checker; successor to the fixed 3-input XOR gate.
- Reduces WIDTH-bit words to one bit and accumulates parity across a multi-word packet.
- Supports even/odd mode and an optional check against a received parity bit.
- Sits between switch/bus capture logic and LED/status or UART framing logic; valid/ready on both sides.

Parameters:
WIDTH, 3, bits per input word (>=1)
MAX_WORDS, 16, max beats per packet before forced termination (>=1)
CW, $clog2(MAX_WORDS+1), width of the beat counter (derived; do not override)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
mode  in  1  0 = even parity, 1 = odd parity; sampled on the first beat of a packet
in_valid  in  1  input word valid
in_ready  out  1  block can accept a word
in_data  in  WIDTH  input word
in_last  in  1  final word of the packet; qualified by in_valid
chk_en  in  1  enable compare; sampled with the last beat
chk_bit  in  1  received parity bit; sampled with the last beat
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_parity  out  1  computed parity bit
out_err  out  1  chk_en was set and out_parity != chk_bit
out_ovf  out  1  packet force-terminated at MAX_WORDS without in_last
out_count  out  CW  number of beats in the packet

Behaviour:
- Reset (rst_n low, async): state=IDLE, acc=0, count=0, mode_q=0, all outputs 0 except in_ready=1 after reset release.
- Handshake: a beat is accepted when in_valid && in_ready. The result transfers when out_valid && out_ready.
- FSM states: IDLE, ACCUM, HOLD.
- in_ready=1 in IDLE and ACCUM, 0 in HOLD. No combinational path from out_ready to in_ready.
- IDLE, beat accepted:
  - mode_q<=mode; acc<=^in_data; count<=1.
  - If in_last or MAX_WORDS==1 -> HOLD; else -> ACCUM.
- ACCUM, beat accepted: acc<=acc^(^in_data); count<=count+1.
- Termination: the packet ends when in_last is set, or when the accepted beat makes count==MAX_WORDS. Either case -> HOLD.
- On entry to HOLD (registered, visible the cycle after the final beat):
  - out_parity = acc_final ^ mode_q.
  - out_err = chk_en_q & (out_parity ^ chk_bit_q).
  - out_ovf = 1 iff the MAX_WORDS limit ended the packet and in_last was 0 on that beat.
  - out_count = final count.
  - out_valid = 1.
- Latency: out_valid rises exactly 1 cycle after the last beat is accepted.
- HOLD:
  - All result outputs are stable while out_valid && !out_ready.
  - On out_ready -> IDLE next cycle; out_valid<=0; acc/count cleared.
  - The result fields keep their last values but are meaningful only while out_valid=1.
- Throughput: one bubble cycle per packet, because in_ready=0 during HOLD.
- mode changes mid-packet are ignored (mode_q is latched on the first beat).
- chk_en/chk_bit are ignored except on the terminating beat. On an overflow termination they are sampled from that beat.
- count never exceeds MAX_WORDS and never wraps.
- in_valid low in ACCUM: hold state indefinitely; no timeout.
- Reset mid-packet or in HOLD: packet discarded, out_valid drops immediately (async), no partial result emitted.

Test Plan:
- WIDTH=3, IDLE, mode=0, one beat 3'b111 in_last=1, out_ready=1 -> next cycle out_valid=1, out_parity=1, out_count=1, out_err=0, out_ovf=0; IDLE after 1 cycle. Repeat with mode=1 -> out_parity=0.
- mode=0, beats 3'b101, 3'b011, 3'b001(last) -> out_parity=1, out_count=3. Same packet with chk_en=1, chk_bit=0 -> out_err=1; with chk_bit=1 -> out_err=0.
- mode=0 latched, then mode toggled to 1 mid-packet; beats 3'b100, 3'b010(last) -> out_parity=0 (even mode kept).
- MAX_WORDS=4, five beats of 3'b001 with no in_last -> after beat 4: out_valid=1, out_ovf=1, out_count=4, out_parity=0, in_ready=0. Beat 5 is not accepted until the result is consumed.
- Hold out_ready=0 for 5 cycles in HOLD -> out_valid, out_parity and out_count unchanged; in_ready=0 throughout. On out_ready=1 the next packet is accepted 1 cycle later.
- Assert rst_n low after 2 beats of a 4-beat packet -> out_valid=0, in_ready=0 during reset. After release a fresh 1-beat packet 3'b110 (mode=0) -> out_parity=0, out_count=1.

Source files
------------

// File: rtl/parity_stream_acc.sv
// Streaming parity generator/checker: folds WIDTH-bit words to one bit and accumulates
// parity over a packet, with even/odd mode, optional compare and overflow at MAX_WORDS.
module parity_stream_acc #(
    parameter int unsigned WIDTH     = 3,
    parameter int unsigned MAX_WORDS = 16,
    parameter int unsigned CW        = $clog2(MAX_WORDS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             chk_en,
    input  logic             chk_bit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_parity,
    output logic             out_err,
    output logic             out_ovf,
    output logic [CW-1:0]    out_count
);

    localparam logic [CW-1:0] MaxCnt = CW'(MAX_WORDS);

    typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

    state_e        state;
    logic          acc;
    logic          mode_q;
    logic [CW-1:0] count;

    logic          accept;
    logic          beat_par;
    logic          acc_nx;
    logic          mode_nx;
    logic [CW-1:0] count_nx;
    logic          hit_max;
    logic          end_pkt;
    logic          par_nx;

    // First beat of a packet restarts the accumulator and latches the mode.
    always_comb begin
        accept   = in_valid && in_ready;
        beat_par = ^in_data;
        acc_nx   = (state == StIdle) ? beat_par : (acc ^ beat_par);
        mode_nx  = (state == StIdle) ? mode : mode_q;
        count_nx = (state == StIdle) ? CW'(1) : (count + CW'(1));
        hit_max  = (count_nx == MaxCnt);
        end_pkt  = in_last || hit_max;
        par_nx   = acc_nx ^ mode_nx;
    end

    // in_ready is registered so it never depends combinationally on out_ready; it comes up
    // one cycle after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            acc        <= 1'b0;
            mode_q     <= 1'b0;
            count      <= '0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_parity <= 1'b0;
            out_err    <= 1'b0;
            out_ovf    <= 1'b0;
            out_count  <= '0;
        end else begin
            unique case (state)
                StIdle, StAccum: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        mode_q <= mode_nx;
                        acc    <= acc_nx;
                        count  <= count_nx;
                        if (end_pkt) begin
                            state      <= StHold;
                            in_ready   <= 1'b0;
                            out_valid  <= 1'b1;
                            out_parity <= par_nx;
                            out_err    <= chk_en & (par_nx ^ chk_bit);
                            out_ovf    <= hit_max & ~in_last;
                            out_count  <= count_nx;
                        end else begin
                            state <= StAccum;
                        end
                    end
                end
                StHold: begin
                    if (out_ready) begin
                        state     <= StIdle;
                        out_valid <= 1'b0;
                        acc       <= 1'b0;
                        count     <= '0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state    <= StIdle;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parity_stream_acc.sv
// Directed bench for parity_stream_acc (WIDTH=3, MAX_WORDS=4): table of single-beat
// packets plus hand sequences for multi-beat, overflow, back-pressure and reset.
module tb_parity_stream_acc;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mode;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_data;
    logic       in_last;
    logic       chk_en;
    logic       chk_bit;
    logic       out_valid;
    logic       out_ready;
    logic       out_parity;
    logic       out_err;
    logic       out_ovf;
    logic [2:0] out_count;

    int tests  = 0;
    int errors = 0;

    parity_stream_acc #(.WIDTH(3), .MAX_WORDS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .chk_en    (chk_en),
        .chk_bit   (chk_bit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_parity(out_parity),
        .out_err   (out_err),
        .out_ovf   (out_ovf),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       mode;
        logic [2:0] data;
        logic       ce;
        logic       cb;
        logic       exp_par;
        logic       exp_err;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; drives one beat across the next posedge, returns at negedge.
    task automatic beat(input logic [2:0] d, input logic l, input logic m,
                        input logic ce, input logic cb);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        mode     = m;
        chk_en   = ce;
        chk_bit  = cb;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk_en   = 1'b0;
        chk_bit  = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b0, 3'b111, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 3'b110, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 3'b100, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 3'b011, 1'b0, 1'b1, 1'b0, 1'b0};

        rst_n = 1'b0; mode = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        chk_en = 1'b0; chk_bit = 1'b0; out_ready = 1'b1;
        #2;
        check("rst_out_valid", 8'(out_valid), 8'd0);
        check("rst_in_ready", 8'(in_ready), 8'd0);
        check("rst_out_count", 8'(out_count), 8'd0);
        check("rst_out_parity", 8'(out_parity), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 8'(in_ready), 8'd1);

        // Single-beat packets
        for (int i = 0; i < 7; i++) begin
            beat(vecs[i].data, 1'b1, vecs[i].mode, vecs[i].ce, vecs[i].cb);
            check($sformatf("v%0d_valid", i), 8'(out_valid), 8'd1);
            check($sformatf("v%0d_parity", i), 8'(out_parity), 8'(vecs[i].exp_par));
            check($sformatf("v%0d_err", i), 8'(out_err), 8'(vecs[i].exp_err));
            check($sformatf("v%0d_count", i), 8'(out_count), 8'd1);
            check($sformatf("v%0d_ovf", i), 8'(out_ovf), 8'd0);
            check($sformatf("v%0d_in_ready_hold", i), 8'(in_ready), 8'd0);
            @(negedge clk);
            check($sformatf("v%0d_valid_drop", i), 8'(out_valid), 8'd0);
            check($sformatf("v%0d_in_ready_idle", i), 8'(in_ready), 8'd1);
        end

        // Three-beat packet, three check settings; compare inputs on early beats are ignored
        for (int k = 0; k < 3; k++) begin
            beat(3'b101, 1'b0, 1'b0, 1'b1, 1'b0);
            beat(3'b011, 1'b0, 1'b0, 1'b1, 1'b0);
            check($sformatf("m%0d_no_early_valid", k), 8'(out_valid), 8'd0);
            beat(3'b001, 1'b1, 1'b0, (k != 0), (k == 2));
            check($sformatf("m%0d_valid", k), 8'(out_valid), 8'd1);
            check($sformatf("m%0d_parity", k), 8'(out_parity), 8'd1);
            check($sformatf("m%0d_count", k), 8'(out_count), 8'd3);
            check($sformatf("m%0d_err", k), 8'(out_err), 8'(k == 1));
            @(negedge clk);
        end

        // Mode toggled mid-packet is ignored
        beat(3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
        beat(3'b010, 1'b1, 1'b1, 1'b0, 1'b0);
        check("mode_latch_parity", 8'(out_parity), 8'd0);
        check("mode_latch_count", 8'(out_count), 8'd2);
        @(negedge clk);

        // Overflow at MAX_WORDS=4 with back-pressure; beat 5 waits on the input
        out_ready = 1'b0;
        beat(3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
        beat(3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
        beat(3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
        beat(3'b001, 1'b0, 1'b0, 1'b1, 1'b1);
        in_valid = 1'b1; in_data = 3'b001; in_last = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("ovf_valid_c%0d", c), 8'(out_valid), 8'd1);
            check($sformatf("ovf_flag_c%0d", c), 8'(out_ovf), 8'd1);
            check($sformatf("ovf_count_c%0d", c), 8'(out_count), 8'd4);
            check($sformatf("ovf_parity_c%0d", c), 8'(out_parity), 8'd0);
            check($sformatf("ovf_err_c%0d", c), 8'(out_err), 8'd1);
            check($sformatf("ovf_in_ready_c%0d", c), 8'(in_ready), 8'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("after_consume_valid", 8'(out_valid), 8'd0);
        check("after_consume_in_ready", 8'(in_ready), 8'd1);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        check("beat5_valid", 8'(out_valid), 8'd1);
        check("beat5_count", 8'(out_count), 8'd1);
        check("beat5_parity", 8'(out_parity), 8'd1);
        check("beat5_ovf", 8'(out_ovf), 8'd0);
        @(negedge clk);

        // Reset mid-packet discards it
        beat(3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
        beat(3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 8'(out_valid), 8'd0);
        check("rst_mid_in_ready", 8'(in_ready), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        beat(3'b110, 1'b1, 1'b0, 1'b0, 1'b0);
        check("fresh_valid", 8'(out_valid), 8'd1);
        check("fresh_parity", 8'(out_parity), 8'd0);
        check("fresh_count", 8'(out_count), 8'd1);
        @(negedge clk);

        // Reset in HOLD drops out_valid asynchronously
        out_ready = 1'b0;
        beat(3'b111, 1'b1, 1'b0, 1'b0, 1'b0);
        check("hold_rst_pre_valid", 8'(out_valid), 8'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("hold_rst_valid", 8'(out_valid), 8'd0);
        check("hold_rst_count", 8'(out_count), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
